sipo_deb: RTL
=============

Name: sipo_deb

Overview:
- Debug/config loader: the receive end of the byte-serial debug stream.
- Accepts a 12-byte frame on D_IN, one byte per SHIFT_DEB strobe, in fixed order: SSFR[15:8], SSFR[7:0], CON_SIG[15:8], CON_SIG[7:0], MAC2[15:8], MAC2[7:0], MAC1[15:8], MAC1[7:0], QD, QC, QB, QA.
- Bytes collect in a shadow buffer. The parallel outputs update atomically only when a complete frame is received.
- Used by the bench/host side to reload NPU state registers.

Parameters:
- GAP_MAX, 255: maximum idle cycles allowed between strobes inside a frame; 0 disables the gap timeout. Width 8 bits.

Ports:
- CLKEXT  in  1  system clock, rising edge
- RST_GLO  in  1  global reset, synchronous, active-high
- EN_SIPO_DEB  in  1  receiver enable
- CLR_SIPO_DEB  in  1  clear pulse, synchronous, active-high
- SHIFT_DEB  in  1  byte strobe; D_IN is sampled on every edge where it is high
- D_IN  in  8  serial byte data
- SSFR  out  16  committed SSFR
- CON_SIG  out  16  committed control word
- MAC2  out  16  committed MAC2
- MAC1  out  16  committed MAC1
- QD, QC, QB, QA  out  8 each  committed queue bytes
- BYTE_CNT  out  4  bytes captured in the current frame
- BUSY  out  1  high when state is not IDLE
- DONE  out  1  one-cycle pulse on commit
- ERR  out  1  one-cycle pulse on abort

Behaviour:
- Reset (RST_GLO high at an edge):
  - All outputs go to 0; shadow buffer cleared; state IDLE; gap counter 0.
- Priority: RST_GLO > CLR_SIPO_DEB > normal operation.
- CLR_SIPO_DEB:
  - Same effect as reset on the parallel outputs, shadow, BYTE_CNT and state.
  - DONE and ERR are 0 that cycle.
- States: IDLE, RECV, COMMIT.
- IDLE:
  - SHIFT_DEB is ignored while EN_SIPO_DEB is low.
  - EN & SHIFT: shadow[0] <= D_IN, BYTE_CNT <= 1, go to RECV.
- RECV:
  - Each EN & SHIFT edge: shadow[BYTE_CNT] <= D_IN, BYTE_CNT++, gap counter <= 0.
  - Strobe at BYTE_CNT==11: capture the byte, go to COMMIT.
  - Gap counter increments on every cycle without a strobe.
  - If GAP_MAX != 0 and the gap counter reaches GAP_MAX: ERR pulse, BYTE_CNT <= 0, shadow discarded, go to IDLE.
  - EN_SIPO_DEB low in RECV: the same abort, with ERR pulse.
- COMMIT (exactly 1 cycle):
  - All parallel outputs load from the shadow simultaneously; DONE=1; BYTE_CNT <= 0; go to IDLE.
  - Latency: outputs and DONE become visible one cycle after the edge that sampled the 12th byte.
  - Back-to-back frames: an EN & SHIFT strobe during COMMIT is captured as byte 0 of the next frame (BYTE_CNT <= 1, state RECV). The commit still completes with the old shadow contents; that cycle's byte must not corrupt the committed values.
- Parallel outputs hold between frames. An aborted frame never alters them.
- A partial frame never reaches the outputs.
- BUSY is combinational from the state: high in RECV and COMMIT.
- DONE and ERR are registered and never high in the same cycle.

Optional Feature:
- Macro: SIPO_DEB_CHK_EN.
- Defined:
  - A 13th byte is required: the XOR of the 12 data bytes.
  - After the 12th byte the FSM enters state CHK; the gap and EN-abort rules still apply; BYTE_CNT reads 12.
  - Checksum strobe matches: go to COMMIT.
  - Mismatch: ERR pulse, no commit, go to IDLE.
- Undefined:
  - No CHK state; commit follows the 12th byte as described above.

Test Plan:
- Send 12 bytes 01,02,...,0C on consecutive strobes, EN=1 -> one cycle after byte 12: SSFR=0102, CON_SIG=0304, MAC2=0506, MAC1=0708, QD=09, QC=0A, QB=0B, QA=0C; DONE high exactly 1 cycle; BUSY low afterwards.
- Send 5 bytes, then hold SHIFT low for GAP_MAX=4 cycles -> ERR pulse, BYTE_CNT=0, outputs keep the previous frame values.
- Mid-frame: pulse CLR after 7 bytes -> all outputs 0, BYTE_CNT 0, IDLE; a following full frame AA..B5 commits correctly.
- Back-to-back: frame A (11..1C) followed by frame B (21..2C) with a strobe in the COMMIT cycle -> DONE twice; final SSFR=2122, QA=2C; intermediate QA=1C.
- Drop EN after 3 bytes -> ERR; SHIFT strobes with EN=0 in IDLE -> BYTE_CNT stays 0, BUSY=0.
- With SIPO_DEB_CHK_EN: frame 01..0C + checksum 0C -> DONE; same frame + checksum 00 -> ERR and outputs unchanged.

Source files
------------

// File: rtl/sipo_deb.sv
// Byte-serial debug/config receiver: collects a 12-byte frame into a shadow buffer and commits it
// atomically to the parallel outputs. Define SIPO_DEB_CHK_EN to require a trailing XOR checksum byte.
module sipo_deb #(
   parameter logic [7:0] GAP_MAX = 8'd255
) (
   input  logic        CLKEXT,
   input  logic        RST_GLO,
   input  logic        EN_SIPO_DEB,
   input  logic        CLR_SIPO_DEB,
   input  logic        SHIFT_DEB,
   input  logic [7:0]  D_IN,
   output logic [15:0] SSFR,
   output logic [15:0] CON_SIG,
   output logic [15:0] MAC2,
   output logic [15:0] MAC1,
   output logic [7:0]  QD,
   output logic [7:0]  QC,
   output logic [7:0]  QB,
   output logic [7:0]  QA,
   output logic [3:0]  BYTE_CNT,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR
);

   typedef enum logic [1:0] {StIdle, StRecv, StCommit, StChk} state_e;

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] gap_q, gap_d;
   logic [7:0] gap_inc;
   logic       gap_hit;
   logic [7:0] shadow_q [12];
   logic [7:0] shadow_d [12];
   logic [7:0] out_q [12];
   logic [7:0] out_d [12];
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       strobe;
   logic       abort;

   assign strobe  = EN_SIPO_DEB & SHIFT_DEB;
   assign gap_inc = gap_q + 8'd1;
   assign gap_hit = (GAP_MAX != 8'd0) && (gap_inc == GAP_MAX);

`ifdef SIPO_DEB_CHK_EN
   logic [7:0] csum;
   always_comb begin
      csum = 8'd0;
      for (int i = 0; i < 12; i++) csum = csum ^ shadow_q[i];
   end
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gap_d    = gap_q;
      shadow_d = shadow_q;
      out_d    = out_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      abort    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (strobe) begin
               shadow_d[0] = D_IN;
               cnt_d       = 4'd1;
               gap_d       = 8'd0;
               state_d     = StRecv;
            end
         end
         StRecv: begin
            if (!EN_SIPO_DEB) begin
               abort = 1'b1;
            end else if (SHIFT_DEB) begin
               shadow_d[cnt_q] = D_IN;
               cnt_d           = cnt_q + 4'd1;
               gap_d           = 8'd0;
               if (cnt_q == 4'd11) begin
`ifdef SIPO_DEB_CHK_EN
                  state_d = StChk;
`else
                  state_d = StCommit;
`endif
               end
            end else begin
               gap_d = gap_inc;
               abort = gap_hit;
            end
         end
`ifdef SIPO_DEB_CHK_EN
         StChk: begin
            if (!EN_SIPO_DEB) begin
               abort = 1'b1;
            end else if (SHIFT_DEB) begin
               if (D_IN == csum) state_d = StCommit;
               else              abort   = 1'b1;
            end else begin
               gap_d = gap_inc;
               abort = gap_hit;
            end
         end
`endif
         StCommit: begin
            // Outputs take the old shadow; a strobe this cycle only starts the next frame.
            out_d   = shadow_q;
            done_d  = 1'b1;
            cnt_d   = 4'd0;
            state_d = StIdle;
            if (strobe) begin
               shadow_d[0] = D_IN;
               cnt_d       = 4'd1;
               gap_d       = 8'd0;
               state_d     = StRecv;
            end
         end
         default: state_d = StIdle;
      endcase
      if (abort) begin
         err_d    = 1'b1;
         cnt_d    = 4'd0;
         gap_d    = 8'd0;
         shadow_d = '{default: 8'd0};
         state_d  = StIdle;
      end
   end

   always_ff @(posedge CLKEXT) begin
      if (RST_GLO || CLR_SIPO_DEB) begin
         state_q  <= StIdle;
         cnt_q    <= 4'd0;
         gap_q    <= 8'd0;
         shadow_q <= '{default: 8'd0};
         out_q    <= '{default: 8'd0};
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         gap_q    <= gap_d;
         shadow_q <= shadow_d;
         out_q    <= out_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign SSFR     = {out_q[0], out_q[1]};
   assign CON_SIG  = {out_q[2], out_q[3]};
   assign MAC2     = {out_q[4], out_q[5]};
   assign MAC1     = {out_q[6], out_q[7]};
   assign QD       = out_q[8];
   assign QC       = out_q[9];
   assign QB       = out_q[10];
   assign QA       = out_q[11];
   assign BYTE_CNT = cnt_q;
   assign BUSY     = (state_q != StIdle);
   assign DONE     = done_q;
   assign ERR      = err_q;

endmodule
